// File: rtl/wb_manager_pkg.sv
// Shared types and default parameters for the queued Wishbone manager.
package wb_manager_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUS  = 2'd1,
        RESP = 2'd2
    } wbm_state_t;

    localparam int DEF_ADDR_W  = 32;
    localparam int DEF_DATA_W  = 32;
    localparam int DEF_QDEPTH  = 4;
    localparam int DEF_TIMEOUT = 255;

endpackage

// File: rtl/wb_req_fifo.sv
// Synchronous request FIFO; pointers carry an extra wrap bit so full and empty
// are told apart without a separate flag.
module wb_req_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   push,
    input  logic                   pop,
    input  logic [WIDTH-1:0]       wdata,
    output logic [WIDTH-1:0]       rdata,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = (AW + 1)'(1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign count   = wr_ptr - rd_ptr;
    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign rdata   = mem[rd_ptr[AW-1:0]];

    // NOTE: non-blocking assignments so both pointers update from pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
            if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
        end
    end

    // NOTE: storage is deliberately not reset; an entry is only read after it is written.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= wdata;
    end

endmodule

// File: rtl/wishbone_queued_manager.sv
// Wishbone classic-cycle manager: queued CPU requests executed in order, one
// response pulse per request, and a bus timeout reported as an error.
module wishbone_queued_manager
    import wb_manager_pkg::*;
#(
    parameter int ADDR_W  = DEF_ADDR_W,
    parameter int DATA_W  = DEF_DATA_W,
    parameter int QDEPTH  = DEF_QDEPTH,
    parameter int TIMEOUT = DEF_TIMEOUT
) (
    input  logic                CLK,
    input  logic                nRST,
    input  logic                REQ_VALID_I,
    output logic                REQ_READY_O,
    input  logic                REQ_WE_I,
    input  logic [ADDR_W-1:0]   ADR_I,
    input  logic [DATA_W-1:0]   CPU_DAT_I,
    input  logic [DATA_W/8-1:0] SEL_I,
    output logic                RSP_VALID_O,
    output logic                RSP_WE_O,
    output logic                RSP_ERR_O,
    output logic [DATA_W-1:0]   CPU_DAT_O,
    output logic                BUSY_O,
    output logic [ADDR_W-1:0]   ADR_O,
    output logic [DATA_W-1:0]   DAT_O,
    output logic [DATA_W/8-1:0] SEL_O,
    output logic                WE_O,
    output logic                STB_O,
    output logic                CYC_O,
    input  logic [DATA_W-1:0]   DAT_I,
    input  logic                ACK_I
);

    localparam int SEL_W = DATA_W / 8;
    localparam int REQ_W = 1 + ADDR_W + DATA_W + SEL_W;
    localparam int CNT_W = $clog2(QDEPTH) + 1;
    localparam bit TMO_EN = (TIMEOUT > 0);
    localparam int TW = TMO_EN ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [TW-1:0] TMO_LAST = TW'(TMO_EN ? TIMEOUT - 1 : 0);
    localparam logic [TW-1:0] TMO_ONE  = TW'(1);

    wbm_state_t       state;
    wbm_state_t       state_next;
    logic [REQ_W-1:0] q_head;
    logic             q_full;
    logic             q_empty;
    logic [CNT_W-1:0] q_count;
    logic             q_push;
    logic             q_pop;
    logic             cur_we;
    logic             err_q;
    logic [TW-1:0]    tmo_cnt;
    logic             ack_hit;
    logic             tmo_hit;

    assign REQ_READY_O = !q_full;
    assign q_push      = REQ_VALID_I && !q_full;
    assign ack_hit     = (state == BUS) && ACK_I;
    assign tmo_hit     = TMO_EN && (state == BUS) && !ACK_I && (tmo_cnt == TMO_LAST);
    assign q_pop       = ack_hit || tmo_hit;

    wb_req_fifo #(
        .WIDTH (REQ_W),
        .DEPTH (QDEPTH)
    ) u_req_fifo (
        .clk   (CLK),
        .rst_n (nRST),
        .push  (q_push),
        .pop   (q_pop),
        .wdata ({REQ_WE_I, ADR_I, CPU_DAT_I, SEL_I}),
        .rdata (q_head),
        .full  (q_full),
        .empty (q_empty),
        .count (q_count)
    );

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) state <= IDLE;
        else       state <= state_next;
    end

    // NOTE: default assignment first so no branch leaves state_next unassigned (no latch).
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (!q_empty) state_next = BUS;
            BUS:     if (q_pop)    state_next = RESP;
            RESP:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Bus strobes and response flags are pure functions of the registered state.
    always_comb begin
        CYC_O       = (state == BUS);
        STB_O       = (state == BUS);
        WE_O        = (state == BUS) && cur_we;
        RSP_VALID_O = (state == RESP);
        RSP_WE_O    = (state == RESP) && cur_we;
        RSP_ERR_O   = (state == RESP) && err_q;
        BUSY_O      = (q_count != '0) || (state != IDLE);
    end

    // Address, data and selects load from the queue head on BUS entry and hold until the next entry.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            ADR_O     <= '0;
            DAT_O     <= '0;
            SEL_O     <= '0;
            cur_we    <= 1'b0;
            CPU_DAT_O <= '0;
            err_q     <= 1'b0;
            tmo_cnt   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (!q_empty) begin
                        {cur_we, ADR_O, DAT_O, SEL_O} <= q_head;
                        tmo_cnt <= '0;
                    end
                end
                BUS: begin
                    if (ACK_I) begin
                        if (!cur_we) CPU_DAT_O <= DAT_I;
                        err_q <= 1'b0;
                    end else begin
                        tmo_cnt <= tmo_cnt + TMO_ONE;
                        if (tmo_hit) err_q <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_wishbone_queued_manager.sv
// Randomised bench for wishbone_queued_manager: a behavioural slave answers the
// bus while a transaction-level memory model predicts every response.
module tb_wishbone_queued_manager;

    localparam int QDEPTH  = 4;
    localparam int TIMEOUT = 8;

    typedef struct {
        bit          we;
        logic [31:0] adr;
        logic [31:0] dat;
        logic [3:0]  sel;
        int          dly;   // cycles of wait before ACK; negative = never ACK
    } txn_t;

    typedef struct {
        bit          we;
        bit          err;
        logic [31:0] dat;
    } rsp_t;

    logic        CLK, nRST;
    logic        REQ_VALID_I, REQ_READY_O, REQ_WE_I;
    logic [31:0] ADR_I, CPU_DAT_I, CPU_DAT_O, ADR_O, DAT_O, DAT_I;
    logic [3:0]  SEL_I, SEL_O;
    logic        RSP_VALID_O, RSP_WE_O, RSP_ERR_O, BUSY_O;
    logic        WE_O, STB_O, CYC_O, ACK_I;

    wishbone_queued_manager #(
        .ADDR_W  (32),
        .DATA_W  (32),
        .QDEPTH  (QDEPTH),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .CLK         (CLK),
        .nRST        (nRST),
        .REQ_VALID_I (REQ_VALID_I),
        .REQ_READY_O (REQ_READY_O),
        .REQ_WE_I    (REQ_WE_I),
        .ADR_I       (ADR_I),
        .CPU_DAT_I   (CPU_DAT_I),
        .SEL_I       (SEL_I),
        .RSP_VALID_O (RSP_VALID_O),
        .RSP_WE_O    (RSP_WE_O),
        .RSP_ERR_O   (RSP_ERR_O),
        .CPU_DAT_O   (CPU_DAT_O),
        .BUSY_O      (BUSY_O),
        .ADR_O       (ADR_O),
        .DAT_O       (DAT_O),
        .SEL_O       (SEL_O),
        .WE_O        (WE_O),
        .STB_O       (STB_O),
        .CYC_O       (CYC_O),
        .DAT_I       (DAT_I),
        .ACK_I       (ACK_I)
    );

    int          checks = 0;
    int          errors = 0;
    txn_t        pend_q[$];
    txn_t        bus_q[$];
    rsp_t        rsp_q[$];
    txn_t        cur;
    logic [31:0] model_mem [logic [29:0]];
    logic [31:0] slave_mem [logic [29:0]];
    logic [31:0] exp_cpu = '0;
    bit          in_bus = 0;
    int          cyc_n = 0;
    int          low_run = 2;
    int          offer_pct = 100;
    bit          stray_en = 0;

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    initial begin
        #2_000_000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] init_word(input logic [29:0] a);
        return {a, 2'b00} ^ 32'h5A5A_A5A5;
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d,
                                          input logic [3:0] sel);
        logic [31:0] w;
        w = old;
        for (int b = 0; b < 4; b++) if (sel[b]) w[8*b +: 8] = d[8*b +: 8];
        return w;
    endfunction

    function automatic logic [31:0] model_rd(input logic [29:0] a);
        return model_mem.exists(a) ? model_mem[a] : init_word(a);
    endfunction

    function automatic logic [31:0] slave_rd(input logic [29:0] a);
        return slave_mem.exists(a) ? slave_mem[a] : init_word(a);
    endfunction

    // Reference model: requests complete in accept order, so each response is
    // the accepted request applied to the memory left by all earlier ones.
    task automatic accept(input txn_t t);
        rsp_t r;
        bus_q.push_back(t);
        r.we  = t.we;
        r.err = (t.dly < 0);
        if (!r.err) begin
            if (t.we) model_mem[t.adr[31:2]] = merge(model_rd(t.adr[31:2]), t.dat, t.sel);
            else      exp_cpu = model_rd(t.adr[31:2]);
        end
        r.dat = exp_cpu;
        rsp_q.push_back(r);
    endtask

    task automatic post(input bit we, input logic [31:0] adr, input logic [31:0] dat,
                        input logic [3:0] sel, input int dly);
        txn_t t;
        t.we = we; t.adr = adr; t.dat = dat; t.sel = sel; t.dly = dly;
        pend_q.push_back(t);
    endtask

    // One clock: observe at the falling edge, play the slave, then drive the CPU side.
    task automatic step();
        rsp_t r;
        @(negedge CLK);
        if (RSP_VALID_O) begin
            if (rsp_q.size() == 0) begin
                check("spurious_rsp", RSP_VALID_O, 1'b0);
            end else begin
                r = rsp_q.pop_front();
                check("rsp_we", RSP_WE_O, r.we);
                check("rsp_err", RSP_ERR_O, r.err);
                check("cpu_dat", CPU_DAT_O, r.dat);
            end
        end
        check("ready", REQ_READY_O, rsp_q.size() < QDEPTH);
        if (rsp_q.size() != 0) check("busy", BUSY_O, 1'b1);

        if (CYC_O) begin
            if (!in_bus) begin
                in_bus = 1;
                cyc_n  = 0;
                check("cyc_gap", low_run >= 2, 1'b1);
                if (bus_q.size() == 0) begin
                    check("spurious_bus", CYC_O, 1'b0);
                    cur.we = WE_O; cur.adr = ADR_O; cur.sel = SEL_O; cur.dat = DAT_O; cur.dly = 0;
                end else begin
                    cur = bus_q.pop_front();
                end
                check("bus_adr", ADR_O, cur.adr);
                check("bus_we", WE_O, cur.we);
                check("bus_sel", SEL_O, cur.sel);
                if (cur.we) check("bus_dat", DAT_O, cur.dat);
            end else begin
                check("bus_hold", {ADR_O, SEL_O}, {cur.adr, cur.sel});
            end
            check("stb", STB_O, 1'b1);
            cyc_n++;
            if (cur.dly >= 0 && cyc_n == cur.dly + 1) begin
                ACK_I = 1'b1;
                if (cur.we) begin
                    slave_mem[ADR_O[31:2]] = merge(slave_rd(ADR_O[31:2]), DAT_O, SEL_O);
                    DAT_I = $urandom;
                end else begin
                    DAT_I = slave_rd(ADR_O[31:2]);
                end
            end else begin
                ACK_I = 1'b0;
                DAT_I = $urandom;
            end
        end else begin
            if (in_bus) begin
                check("cyc_len", cyc_n, (cur.dly < 0) ? TIMEOUT : cur.dly + 1);
                in_bus  = 0;
                low_run = 0;
            end
            low_run++;
            check("stb_low", {STB_O, WE_O}, 2'b00);
            ACK_I = stray_en ? 1'($urandom_range(1)) : 1'b0;
            DAT_I = $urandom;
        end

        if (pend_q.size() != 0 && int'($urandom_range(99)) < offer_pct) begin
            REQ_VALID_I = 1'b1;
            REQ_WE_I    = pend_q[0].we;
            ADR_I       = pend_q[0].adr;
            CPU_DAT_I   = pend_q[0].dat;
            SEL_I       = pend_q[0].sel;
        end else begin
            REQ_VALID_I = 1'b0;
            REQ_WE_I    = 1'($urandom_range(1));
            ADR_I       = $urandom;
            CPU_DAT_I   = $urandom;
            SEL_I       = 4'($urandom);
        end
        if (REQ_VALID_I && REQ_READY_O) accept(pend_q.pop_front());
    endtask

    task automatic drain(input int budget);
        int n;
        n = 0;
        while ((pend_q.size() != 0 || rsp_q.size() != 0) && n < budget) begin
            step();
            n++;
        end
        check("drain_left", pend_q.size() + rsp_q.size(), 0);
        repeat (2) step();
    endtask

    task automatic check_reset(input string pfx);
        check({pfx, "_ready"}, REQ_READY_O, 1'b1);
        check({pfx, "_rsp"}, {RSP_VALID_O, RSP_WE_O, RSP_ERR_O}, 3'b000);
        check({pfx, "_cpu_dat"}, CPU_DAT_O, 32'h0);
        check({pfx, "_busy"}, BUSY_O, 1'b0);
        check({pfx, "_bus_ctl"}, {CYC_O, STB_O, WE_O}, 3'b000);
        check({pfx, "_bus_dat"}, {ADR_O, DAT_O, SEL_O}, 68'h0);
    endtask

    initial begin
        nRST = 1'b0; REQ_VALID_I = 1'b0; REQ_WE_I = 1'b0; ADR_I = '0;
        CPU_DAT_I = '0; SEL_I = '0; DAT_I = '0; ACK_I = 1'b0;
        #12;
        check_reset("rst");
        @(negedge CLK);
        nRST = 1'b1;

        // Write then read back, with first-request latency.
        post(1, 32'h3300_0000, 32'h1234_5678, 4'hF, 1);
        post(0, 32'h3300_0000, 32'h0, 4'hF, 0);
        step();
        step(); check("lat_edge_k", CYC_O, 1'b0);
        step(); check("lat_edge_k1", CYC_O, 1'b1);
        drain(200);
        check("wr_rd_data", CPU_DAT_O, 32'h1234_5678);

        // Timeout read, then a queued request behind it.
        post(0, 32'h3000_0010, 32'h0, 4'hF, -1);
        post(1, 32'h3300_0004, 32'hCAFE_F00D, 4'hF, 0);
        drain(200);
        check("tmo_hold", CPU_DAT_O, 32'h1234_5678);

        // Byte-lane write over an existing word.
        post(1, 32'h3300_0008, 32'h1122_3344, 4'hF, 0);
        post(1, 32'h3300_0008, 32'hAABB_CCDD, 4'b0010, 2);
        post(0, 32'h3300_0008, 32'h0, 4'hF, 1);
        drain(200);
        check("byte_rd", CPU_DAT_O, 32'h1122_CC44);

        // Five writes against a slow slave fill the queue.
        for (int i = 0; i < 5; i++) post(1, 32'h3300_0010 + 32'(4 * i), 32'(i + 1), 4'hF, 3);
        repeat (5) step();
        check("full_ready", REQ_READY_O, 1'b0);
        check("full_pend", pend_q.size(), 1);
        drain(300);

        // Continuous pushes while each ACK pops: push and pop share edges.
        for (int i = 0; i < 8; i++) post(1, 32'h3300_0000 + 32'(4 * (i % 8)), $urandom, 4'hF, 0);
        drain(300);

        // Stray ACK while idle is ignored.
        stray_en = 1;
        repeat (4) step();
        check("stray_busy", BUSY_O, 1'b0);
        check("stray_rsp", RSP_VALID_O, 1'b0);

        // Reset while a bus cycle runs and more requests wait.
        for (int i = 0; i < 4; i++) post(0, 32'h3300_0000 + 32'(4 * i), $urandom, 4'hF, 3);
        repeat (5) step();
        check("mid_cyc_before", CYC_O, 1'b1);
        #2 nRST = 1'b0;
        #1 check_reset("mid");
        pend_q.delete(); bus_q.delete(); rsp_q.delete();
        in_bus = 0; low_run = 2; exp_cpu = '0;
        REQ_VALID_I = 1'b0; ACK_I = 1'b0;
        @(posedge CLK);
        #1 check("mid_hold_cyc", CYC_O, 1'b0);
        @(negedge CLK);
        #2 nRST = 1'b1;
        repeat (5) step();
        check("post_rst_busy", BUSY_O, 1'b0);
        check("post_rst_rsp", RSP_VALID_O, 1'b0);

        // Randomised traffic with occasional timeouts and partial-byte writes.
        offer_pct = 70;
        for (int i = 0; i < 250; i++) begin
            post(1'($urandom_range(1)),
                 32'h3300_0000 + 32'(4 * $urandom_range(7)),
                 $urandom,
                 ($urandom_range(3) == 0) ? 4'($urandom) : 4'hF,
                 ($urandom_range(9) == 0) ? -1 : int'($urandom_range(3)));
        end
        drain(5000);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/wishbone_queued_manager.md
# wishbone_queued_manager

Parametrised Wishbone classic-cycle bus manager with an in-order request queue, valid/ready CPU handshake, per-transaction response pulses and a bus timeout. Sits between a CPU-side load/store unit and the wishbone arbitrator, replacing the single-outstanding WRITE/READ/BUSY manager. The CPU can post up to QDEPTH requests without stalling, and a missing ACK is reported as an error instead of hanging the bus.

## Interface
- ADDR_W, 32, address width.
- DATA_W, 32, data width; must be a multiple of 8.
- QDEPTH, 4, request queue entries; must be a power of 2 and ≥2.
- TIMEOUT, 255, maximum bus cycles waiting for ACK; 0 disables the timeout.

Ports:
- CLK  in  1  clock; one clock domain, everything sampled on the rising edge.
- nRST  in  1  reset; asynchronous, active-low.
- REQ_VALID_I  in  1  CPU request valid.
- REQ_READY_O  out  1  queue can accept a request.
- REQ_WE_I  in  1  1 = write, 0 = read.
- ADR_I  in  ADDR_W  request address.
- CPU_DAT_I  in  DATA_W  write data.
- SEL_I  in  DATA_W/8  byte selects.
- RSP_VALID_O  out  1  one-cycle response pulse.
- RSP_WE_O  out  1  response belongs to a write.
- RSP_ERR_O  out  1  transaction timed out.
- CPU_DAT_O  out  DATA_W  read data; held until the next response.
- BUSY_O  out  1  queue non-empty or a bus cycle is in progress.
- ADR_O / DAT_O / SEL_O / WE_O / STB_O / CYC_O  out  ADDR_W / DATA_W / DATA_W/8 / 1 / 1 / 1  Wishbone manager outputs.
- DAT_I  in  DATA_W  Wishbone read data.
- ACK_I  in  1  Wishbone acknowledge.

## Operation
- Accept: a request enters the queue on a rising edge where REQ_VALID_I && REQ_READY_O.
  - Queued fields: {we, adr, dat, sel}.
  - REQ_READY_O = !full. It is a register function of the queue count only, with no combinational path from pop.
- Order: requests execute strictly in order, with one bus cycle at a time.
- FSM states: IDLE, BUS, RESP.
  - IDLE → BUS when the queue is non-empty. On this edge the outputs load from the queue head and CYC_O = STB_O = 1.
  - BUS → RESP on a sampled ACK_I, or when the timeout counter reaches TIMEOUT.
    - On the ACK path: capture DAT_I into CPU_DAT_O if the transaction is a read.
    - On the timeout path: leave CPU_DAT_O unchanged and set the error flag.
  - On the BUS → RESP edge:
    - CYC_O, STB_O and WE_O drop to 0.
    - The queue head pops.
    - RSP_VALID_O = 1 for exactly the RESP cycle, with RSP_WE_O and RSP_ERR_O valid alongside it.
  - RESP → IDLE unconditionally.
- Every accepted request produces exactly one RSP_VALID_O pulse, including writes.
- ADR_O, DAT_O and SEL_O are held stable for the whole BUS state.
- Timeout counter:
  - Width $clog2(TIMEOUT+1).
  - Cleared on entry to BUS; increments each BUS cycle without ACK.
- ACK_I outside BUS is ignored.
- BUSY_O = (count != 0) || (state != IDLE).

## Timing
- Reset values (asynchronous):
  - State IDLE, queue empty.
  - REQ_READY_O = 1.
  - All other outputs 0, including CPU_DAT_O.
- Latency from request accept at edge k:
  - If IDLE with the queue empty, CYC_O/STB_O rise after edge k+1.
  - An ACK sampled at edge m gives RSP_VALID_O high in the cycle after m.
- Minimum spacing: back-to-back queued transactions go BUS → RESP → IDLE → BUS, so CYC_O is low for 2 cycles between them.
- Timeout fires at the edge where TIMEOUT consecutive non-ACK BUS cycles have elapsed.
- Simultaneous push and pop:
  - Both are allowed in the same cycle; the count is unchanged.
  - When full, a push is refused even if a pop happens that cycle (READY was already low).
- A reset asserted mid-BUS drops CYC_O/STB_O immediately, discards queued requests and generates no response.

## Structure
- Package wb_manager_pkg holds:
  - Enum wbm_state_t {IDLE, BUS, RESP}.
  - Default parameter localparams.
- Sub-module wb_req_fifo (synchronous FIFO, parameters WIDTH and DEPTH):
  - Ports: push/pop, full/empty, count, head data.
  - Wrap-around pointers with an extra MSB.
  - Instantiated once with WIDTH = 1+ADDR_W+DATA_W+DATA_W/8.

## Test plan
- Write then read, with the sram wrapper behind the decoder:
  - Stimulus: write 0x33000000 ← 0x12345678, then read 0x33000000.
  - Required: two RSP_VALID_O pulses, RSP_ERR_O = 0 on both, CPU_DAT_O = 0x12345678 after the read.
- Queue full with QDEPTH = 4 and ACK held low:
  - Stimulus: post 5 writes.
  - Required: REQ_READY_O drops after the 4th; the 5th is held until the first pop; all 5 complete in order, with addresses checked on ADR_O.
- Timeout with TIMEOUT = 8 and no ACK:
  - Stimulus: read at 0x30000010.
  - Required: CYC_O high for exactly 8 cycles; RSP_VALID_O with RSP_ERR_O = 1; CPU_DAT_O unchanged; the next queued request proceeds.
- Byte write:
  - Stimulus: write 0xAABBCCDD with SEL 4'b0010 over existing 0x11223344, then read back.
  - Required: read data 0x1122CC44.
- Reset mid-BUS with 3 requests queued:
  - Stimulus: assert nRST low.
  - Required: all outputs return to reset values asynchronously; BUSY_O = 0 and no RSP_VALID_O after release.
- Simultaneous push and pop at count 2:
  - Stimulus: accept a push on the same edge as an ACK.
  - Required: count stays 2 and the response order is preserved.
